// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package reg_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Index increment that wraps back to zero at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic                    valid
);
  import reg_arb_pkg::*;

  always_comb begin
    int unsigned idx;
    gnt   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter owning one shared register, with bounded lock bursts.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic [NREQ-1:0]         REQ,
  input  logic [NREQ-1:0]         LOCK,
  input  logic [NREQ*WIDTH-1:0]   D,
  output logic [NREQ-1:0]         GNT,
  output logic [WIDTH-1:0]        Q,
  output logic [$clog2(NREQ)-1:0] OWNER,
  output logic                    WRITTEN,
  output logic                    BUSY
);

  localparam int PW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_t    state, state_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [PW-1:0] lck, lck_n;
  logic [HW-1:0] hcnt, hcnt_n;

  logic [NREQ-1:0] pick_gnt;
  logic            pick_valid;
  logic [PW-1:0]   win;
  logic            wr;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (REQ),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // Locked owner bypasses the picker; reset forces the grant low.
  always_comb begin
    GNT = '0;
    if (!RESET) begin
      if (state == ARB_IDLE) GNT = pick_gnt;
      else                   GNT[lck] = REQ[lck];
    end
  end

  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (GNT[i]) win = PW'(i);
    end
  end

  assign wr = |GNT;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    lck_n   = lck;
    hcnt_n  = hcnt;
    case (state)
      ARB_IDLE: begin
        if (wr && pick_valid) begin
          if (LOCK[win] && (MAX_HOLD > 1)) begin
            state_n = ARB_LOCKED;
            lck_n   = win;
            hcnt_n  = HW'(1);
          end else begin
            ptr_n = PW'(wrap_inc(32'(win), NREQ));
          end
        end
      end
      ARB_LOCKED: begin
        if (wr) begin
          if (!LOCK[lck] || ((hcnt + HW'(1)) == HW'(MAX_HOLD))) begin
            state_n = ARB_IDLE;
            ptr_n   = PW'(wrap_inc(32'(lck), NREQ));
            hcnt_n  = '0;
          end else begin
            hcnt_n = hcnt + HW'(1);
          end
        end else if (!LOCK[lck]) begin
          state_n = ARB_IDLE;
          ptr_n   = PW'(wrap_inc(32'(lck), NREQ));
          hcnt_n  = '0;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state   <= ARB_IDLE;
      ptr     <= '0;
      lck     <= '0;
      hcnt    <= '0;
      Q       <= '0;
      OWNER   <= '0;
      WRITTEN <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      lck     <= lck_n;
      hcnt    <= hcnt_n;
      WRITTEN <= wr;
      if (wr) begin
        Q     <= D[32'(win)*WIDTH +: WIDTH];
        OWNER <= win;
      end
    end
  end

  assign BUSY = (state == ARB_LOCKED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scenario bench for reg_write_arbiter with a write scoreboard checked by a monitor.
module tb_reg_write_arbiter;

  localparam int WIDTH    = 32;
  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 4;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         lock;
  logic [NREQ*WIDTH-1:0]   d;
  logic [NREQ-1:0]         gnt;
  logic [WIDTH-1:0]        q;
  logic [1:0]              owner;
  logic                    written;
  logic                    busy;

  int total = 0;
  int bad   = 0;

  logic [WIDTH+1:0] sb[$];

  reg_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .CLOCK   (clk),
    .RESET   (rst),
    .REQ     (req),
    .LOCK    (lock),
    .D       (d),
    .GNT     (gnt),
    .Q       (q),
    .OWNER   (owner),
    .WRITTEN (written),
    .BUSY    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each WRITTEN pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (written === 1'b1) begin
      logic [WIDTH+1:0] e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write q=%h owner=%0d required=no write", q, owner);
      end else begin
        e = sb.pop_front();
        if (q !== e[WIDTH+1:2] || owner !== e[1:0]) begin
          bad++;
          $display("FAIL write_data q=%h owner=%0d required q=%h owner=%0d",
                   q, owner, e[WIDTH+1:2], e[1:0]);
        end
      end
    end
  end

  function automatic logic [WIDTH+1:0] exp_write(input int i);
    return {32'h1000_0000 + 32'(i), 2'(i)};
  endfunction

  // Drive one cycle: inputs, settle, check grant, optionally expect a write, clock.
  task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic [3:0] exp_gnt,
                     input string name);
    req  = r;
    lock = l;
    #1;
    total++;
    if (gnt !== exp_gnt) begin
      bad++;
      $display("FAIL %s gnt=%b required=%b", name, gnt, exp_gnt);
    end
    for (int i = 0; i < NREQ; i++) if (exp_gnt[i]) sb.push_back(exp_write(i));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_busy(input logic exp, input string name);
    total++;
    if (busy !== exp) begin
      bad++;
      $display("FAIL %s busy=%b required=%b", name, busy, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 4'b1111;
    #1;
    total++;
    if (gnt !== 4'b0000 || q !== '0 || owner !== 2'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state gnt=%b q=%h owner=%0d busy=%b required 0000/0/0/0",
               gnt, q, owner, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) cyc(4'b0000, 4'b0000, 4'b0000, "idle_gnt");
    chk_busy(1'b0, "idle_busy");
  endtask

  task automatic test_rotation;
    for (int k = 0; k < 4; k++) cyc(4'b1111, 4'b0000, 4'(1 << k), "rotation");
    req = 4'b1111;
    #1;
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL ptr_wrap gnt=%b required=0001", gnt);
    end
    req = 4'b0000;
    @(posedge clk);
    #1;
  endtask

  task automatic test_lock_burst;
    cyc(4'b0010, 4'b0000, 4'b0010, "burst_setup");
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0101, 4'b0100, 4'b0100, "burst_gnt");
      chk_busy(1'b1, "burst_busy");
    end
    cyc(4'b0101, 4'b0100, 4'b0100, "burst_last");
    chk_busy(1'b0, "burst_release");
    cyc(4'b0001, 4'b0000, 4'b0001, "after_burst");
  endtask

  task automatic test_lock_pause;
    cyc(4'b0010, 4'b0010, 4'b0010, "pause_lock");
    chk_busy(1'b1, "pause_busy0");
    for (int k = 0; k < 3; k++) begin
      cyc(4'b1000, 4'b0010, 4'b0000, "pause_gnt");
      chk_busy(1'b1, "pause_busy");
    end
    cyc(4'b1000, 4'b0000, 4'b0000, "pause_drop");
    chk_busy(1'b0, "pause_unlocked");
    cyc(4'b1000, 4'b0000, 4'b1000, "pause_next");
  endtask

  task automatic test_early_unlock;
    cyc(4'b0001, 4'b0001, 4'b0001, "early_lock");
    chk_busy(1'b1, "early_busy");
    cyc(4'b0001, 4'b0000, 4'b0001, "early_unlock");
    chk_busy(1'b0, "early_release");
    cyc(4'b0011, 4'b0000, 4'b0010, "early_ptr");
  endtask

  task automatic test_reset_mid_lock;
    cyc(4'b0100, 4'b0100, 4'b0100, "midlock_w1");
    cyc(4'b0100, 4'b0100, 4'b0100, "midlock_w2");
    chk_busy(1'b1, "midlock_busy");
    req  = 4'b0000;
    lock = 4'b0000;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || q !== '0 || owner !== 2'd0 || gnt !== 4'b0000) begin
      bad++;
      $display("FAIL midlock_reset busy=%b q=%h owner=%0d gnt=%b required 0/0/0/0000",
               busy, q, owner, gnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(4'b1000, 4'b0000, 4'b1000, "post_reset_gnt");
    chk_busy(1'b0, "post_reset_busy");
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 8; k++) cyc(4'b1111, 4'b0000, 4'(1 << (k % 4)), "b2b");
    cyc(4'b0000, 4'b0000, 4'b0000, "b2b_drain");
  endtask

  initial begin
    rst  = 1'b0;
    req  = '0;
    lock = '0;
    for (int i = 0; i < NREQ; i++) d[i*WIDTH +: WIDTH] = 32'h1000_0000 + 32'(i);
    #1;
    test_reset();
    test_rotation();
    test_lock_burst();
    test_lock_pause();
    test_early_unlock();
    test_reset_mid_lock();
    test_back_to_back();
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL missing_writes pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
